// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, one full-adder bit per clock, LSB first.
//
// Ports:
//   clk    - clock; all state changes on its rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request a new operation (sampled only in IDLE)
//   sub    - 0: a+b+cin, 1: a-b (sampled with start)
//   a, b   - WIDTH-bit operands (sampled with start)
//   cin    - carry-in for add; ignored when sub=1
//   busy   - high whenever the FSM is not IDLE
//   done   - one-cycle pulse; sum/cout (and ovf) valid
//   sum    - registered WIDTH-bit result, modulo 2^WIDTH
//   cout   - carry out of the MSB (for subtract, 1 = no borrow)
//   ovf    - signed overflow; exists only when SERIAL_ADDER_OVF_EN is defined
//
// Configuration: define SERIAL_ADDER_OVF_EN to add the ovf port and its logic.
//
// Timing: accept edge -> WIDTH RUN cycles -> one DONE cycle -> IDLE, so one
// result every WIDTH+2 cycles at best.

module serial_adder #(
  parameter int unsigned WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;      // operand A, shifted right each RUN cycle
  logic [WIDTH-1:0] b_q;      // operand B (already inverted for subtract)
  logic [WIDTH-1:0] acc_q;    // partial result; new bits enter at the MSB
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;

  logic bit_s;
  logic bit_c;

  // Full adder on the current LSBs.
  assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            // Subtract as a + ~b + 1.
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub | cin;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= bit_c;
          acc_q   <= {bit_s, acc_q[WIDTH-1:1]};
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IdxW'(WIDTH - 1)) begin
            // Last bit: publish the whole result at once.
            sum     <= {bit_s, acc_q[WIDTH-1:1]};
            cout    <= bit_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB.
            ovf     <= carry_q ^ bit_c;
`endif
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder (WIDTH=8) against an
// arithmetic reference model. ovf is checked only when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int unsigned  n_pass  = 0;
  int unsigned  n_total = 0;

  // Last result the DUT should be holding.
  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  always #5 clk = ~clk;

  serial_adder #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                         input logic osub, input logic ocin);
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic         ov;
    bx   = osub ? ~ob : ob;
    full = {1'b0, oa} + {1'b0, bx} + {{W{1'b0}}, (osub ? 1'b1 : ocin)};
    ov   = (oa[W-1] == bx[W-1]) && (full[W-1] != oa[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  task automatic check_result();
    check("sum", sum, last_sum);
    check("cout", cout, last_cout);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", ovf, last_ovf);
`endif
  endtask

  // Accept one operation and follow it to done. With scramble set, start stays high
  // and the inputs change every cycle while the operation runs.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic osub, input logic ocin, input bit scramble);
    logic [W+1:0] e;
    int           cyc;
    e     = model(oa, ob, osub, ocin);
    a     = oa;
    b     = ob;
    sub   = osub;
    cin   = ocin;
    start = 1'b1;
    tick();
    if (!scramble) start = 1'b0;
    check("busy_after_accept", busy, 1);
    cyc = 0;
    while (!done && cyc < 4 * W) begin
      check("sum_hold_in_run", sum, last_sum);
      check("busy_in_run", busy, 1);
      if (scramble) begin
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
      end
      tick();
      cyc++;
    end
    check("latency", cyc, W);
    check("busy_at_done", busy, 1);
    last_sum  = e[W-1:0];
    last_cout = e[W];
    last_ovf  = e[W+1];
    check_result();
    if (!scramble) begin
      tick();
      check("done_pulse_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
      check_result();
    end
  endtask

  initial begin
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    rst_n = 1'b1;
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    // Reset state, with start asserted to show it is not accepted in reset.
    start = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_result();
    tick();
    tick();
    check("rst_no_accept", busy, 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_no_start", busy, 0);

    // Directed vectors.
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b1, 0);
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 0);

    // Start held high with changing inputs: one result, re-accept after DONE.
    run_op(8'h3A, 8'h5C, 1'b0, 1'b1, 1);
    a   = 8'h11;
    b   = 8'h22;
    sub = 1'b1;
    cin = 1'b0;
    tick();
    check("no_accept_in_done", busy, 0);
    check("done_cleared", done, 0);
    check_result();
    run_op(8'h11, 8'h22, 1'b1, 1'b0, 0);

    // Reset in RUN cycle 4 aborts the operation.
    a     = 8'h3C;
    b     = 8'h21;
    sub   = 1'b0;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check_result();
    tick();
    check("abort_no_accept", busy, 0);
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < int'(W) + 3; i++) begin
      tick();
      check("no_done_after_abort", done, 0);
    end
    check_result();
    run_op(8'h3C, 8'h21, 1'b0, 1'b0, 0);

    // Random operations.
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 = add (a+b+cin), 1 = subtract (a-b); sampled with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands; sampled with start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in for add; ignored when sub=1.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sum/cout valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of the MSB; for subtract, 1 = no borrow.
REQ-012 The block SHALL have port ovf, output, 1 bit: signed overflow; present only per REQ-027.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 Start accept: IDLE with start=1 at an edge SHALL capture a, b XOR {WIDTH{sub}} and carry = sub ? 1 : cin; clear the bit index to 0; go to RUN.
REQ-015 RUN SHALL evaluate exactly one full-adder bit per cycle, LSB first; the carry flop feeds the next bit and the result bit shifts into an internal register.
REQ-016 RUN SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL load sum and cout and enter DONE.
REQ-017 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the accepting edge, for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-018 sum, cout and ovf SHALL change only on entry to DONE and hold until the next result is loaded; intermediate bits SHALL NOT be visible on sum.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing; the earliest next accept is the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.
REQ-020 Wrap-around: results SHALL be modulo 2^WIDTH, with the overflowing carry reported only on cout.
REQ-021 Input changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-022 rst_n low SHALL immediately force the state to IDLE, with busy=0, done=0, sum=0, cout=0 and ovf=0, and clear all internal registers.
REQ-023 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-024 start SHALL NOT be accepted while rst_n is low; the first possible accept is the first rising edge with rst_n high.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN SHALL control the overflow feature.
REQ-026 When SERIAL_ADDER_OVF_EN is defined, port ovf SHALL exist and be loaded on entry to DONE with (carry into MSB) XOR (carry out of MSB).
REQ-027 When SERIAL_ADDER_OVF_EN is undefined, port ovf and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=8, SERIAL_ADDER_OVF_EN defined)
REQ-028 a=8'h0F, b=8'h01, cin=0, sub=0, start -> done exactly 8 cycles after the accept edge, sum=8'h10, cout=0, ovf=0, busy high for 9 cycles.
REQ-029 a=8'hFF, b=8'h01, cin=1, sub=0 -> sum=8'h01, cout=1, ovf=0.
REQ-030 a=8'h05, b=8'h07, sub=1, cin=1 (ignored) -> sum=8'hFE, cout=0, ovf=0.
REQ-031 a=8'h7F, b=8'h01, sub=0, cin=0 -> sum=8'h80, ovf=1; then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, ovf=1, cout=1.
REQ-032 start held high with changing a/b during RUN -> a single result from the first operands; a second accept occurs in the first IDLE cycle after done.
REQ-033 rst_n low in RUN cycle 4 -> busy=0 and sum=0 immediately; no done pulse; a fresh operation after release gives a correct result.
